// File: rtl/ddr3_burst_engine.sv
// DDRAM traffic engine: back-to-back read/write bursts with a programmable gap,
// a seed-based write pattern, and read-back verification in alternate mode.
module ddr3_burst_engine #(
  parameter int unsigned       ADDR_W    = 29,
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       BURST_LEN = 128,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(29'h2400000),
  parameter int unsigned       GAP_W     = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [GAP_W-1:0]      gap,
  input  logic                  stop_safe,
  input  logic                  abort,
  input  logic [DATA_W-1:0]     seed,
  input  logic                  ddram_busy,
  output logic [7:0]            ddram_burstcnt,
  output logic [ADDR_W-1:0]     ddram_addr,
  input  logic [DATA_W-1:0]     ddram_dout,
  input  logic                  ddram_dout_ready,
  output logic                  ddram_rd,
  output logic [DATA_W-1:0]     ddram_din,
  output logic [DATA_W/8-1:0]   ddram_be,
  output logic                  ddram_we,
  output logic                  active,
  output logic                  stopped,
  output logic [31:0]           burst_count,
  output logic [15:0]           err_count,
  output logic [7:0]            first_err_beat
);

  localparam int unsigned BE_W      = DATA_W / 8;
  localparam logic [7:0]  LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [7:0]  BURSTCNT  = 8'(BURST_LEN);
  localparam logic [1:0]  MODE_WR   = 2'd1;
  localparam logic [1:0]  MODE_ALT  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_RD_REQ, S_RD_DATA, S_WR_DATA, S_STOPPED
  } state_t;

  state_t              r_state;
  logic [1:0]          r_mode;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [7:0]          r_beat;
  logic                r_alt_wr;
  logic                r_drain;
  logic                r_err_seen;
  logic                r_rd;
  logic                r_we;
  logic [7:0]          r_burstcnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din;
  logic [BE_W-1:0]     r_be;
  logic                r_active;
  logic                r_stopped;
  logic [31:0]         r_burst_count;
  logic [15:0]         r_err_count;
  logic [7:0]          r_first_err_beat;

  logic                w_next_wr;
  logic                w_last;
  logic                w_drain;
  logic [DATA_W-1:0]   w_pattern;
  logic [DATA_W-1:0]   w_pattern_nxt;
  logic                w_mismatch;
  logic [15:0]         w_err_inc;

  assign w_next_wr     = (r_mode == MODE_WR) || ((r_mode == MODE_ALT) && r_alt_wr);
  assign w_last        = (r_beat == LAST_BEAT);
  assign w_drain       = r_drain || abort;
  assign w_pattern     = seed + DATA_W'(r_beat);
  assign w_pattern_nxt = w_pattern + DATA_W'(1);
  assign w_mismatch    = (ddram_dout != w_pattern);
  assign w_err_inc     = (r_err_count == 16'hFFFF) ? r_err_count : r_err_count + 16'd1;

  // NOTE: reset is synchronous, so it sits inside the clocked block and wins over every branch below.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_mode           <= '0;
      r_gap_cnt        <= '0;
      r_beat           <= '0;
      r_alt_wr         <= 1'b0;
      r_drain          <= 1'b0;
      r_err_seen       <= 1'b0;
      r_rd             <= 1'b0;
      r_we             <= 1'b0;
      r_burstcnt       <= '0;
      r_addr           <= '0;
      r_din            <= '0;
      r_be             <= '0;
      r_active         <= 1'b0;
      r_stopped        <= 1'b0;
      r_burst_count    <= '0;
      r_err_count      <= '0;
      r_first_err_beat <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_STOPPED: begin
          if (start) begin
            r_state          <= S_GAP;
            r_gap_cnt        <= '0;
            r_mode           <= mode;
            r_alt_wr         <= 1'b1;
            r_burst_count    <= '0;
            r_err_count      <= '0;
            r_first_err_beat <= '0;
            r_err_seen       <= 1'b0;
            r_active         <= 1'b1;
            r_stopped        <= 1'b0;
          end
        end

        S_GAP: begin
          if (abort) begin
            r_state   <= S_STOPPED;
            r_active  <= 1'b0;
            r_stopped <= 1'b1;
          end else if (r_gap_cnt >= gap) begin
            r_beat     <= '0;
            r_burstcnt <= BURSTCNT;
            r_addr     <= BASE_ADDR;
            if (r_mode == MODE_ALT) r_alt_wr <= ~r_alt_wr;
            if (w_next_wr) begin
              r_state <= S_WR_DATA;
              r_we    <= 1'b1;
              r_be    <= '1;
              r_din   <= seed;
            end else begin
              r_state <= S_RD_REQ;
              r_rd    <= 1'b1;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end

        S_RD_REQ: begin
          if (abort) begin
            r_rd      <= 1'b0;
            r_state   <= S_STOPPED;
            r_active  <= 1'b0;
            r_stopped <= 1'b1;
          end else if (!ddram_busy) begin
            r_rd    <= 1'b0;
            r_state <= S_RD_DATA;
            r_beat  <= '0;
            r_drain <= 1'b0;
          end
        end

        S_RD_DATA: begin
          // NOTE: the later r_drain clear on the final beat overrides this set; last non-blocking write wins.
          if (abort) r_drain <= 1'b1;
          if (ddram_dout_ready) begin
            r_beat <= r_beat + 8'd1;
            if (!w_drain && (r_mode == MODE_ALT) && w_mismatch) begin
              r_err_count <= w_err_inc;
              if (!r_err_seen) begin
                r_err_seen       <= 1'b1;
                r_first_err_beat <= r_beat;
              end
            end
            if (w_last) begin
              r_drain <= 1'b0;
              if (w_drain || stop_safe) begin
                r_state   <= S_STOPPED;
                r_active  <= 1'b0;
                r_stopped <= 1'b1;
              end else begin
                r_state   <= S_GAP;
                r_gap_cnt <= '0;
              end
              if (!w_drain) r_burst_count <= r_burst_count + 32'd1;
            end
          end
        end

        S_WR_DATA: begin
          if (abort) begin
            r_we      <= 1'b0;
            r_be      <= '0;
            r_state   <= S_STOPPED;
            r_active  <= 1'b0;
            r_stopped <= 1'b1;
          end else if (!ddram_busy) begin
            if (w_last) begin
              r_we          <= 1'b0;
              r_be          <= '0;
              r_burst_count <= r_burst_count + 32'd1;
              if (stop_safe) begin
                r_state   <= S_STOPPED;
                r_active  <= 1'b0;
                r_stopped <= 1'b1;
              end else begin
                r_state   <= S_GAP;
                r_gap_cnt <= '0;
              end
            end else begin
              r_beat <= r_beat + 8'd1;
              r_din  <= w_pattern_nxt;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ddram_rd       = r_rd;
  assign ddram_we       = r_we;
  assign ddram_burstcnt = r_burstcnt;
  assign ddram_addr     = r_addr;
  assign ddram_din      = r_din;
  assign ddram_be       = r_be;
  assign active         = r_active;
  assign stopped        = r_stopped;
  assign burst_count    = r_burst_count;
  assign err_count      = r_err_count;
  assign first_err_beat = r_first_err_beat;

endmodule
